mem_uart_bridge: RTL

Converts native core memory transactions (valid/ready/addr/wdata/wstrb/rdata) into byte-stream packets for a host-side memory server reached over UART. It sits between the cache's memory side (or the core directly) and the uart_tx/uart_rx byte streams. It is a parametrised successor to the fixed 32-bit UART memory path, and adds:
- configurable address and data widths
- posted-write mode
- response timeout with error reporting
- stale-RX flushing

---
 rtl/mem_uart_bridge.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_uart_bridge.sv
// Bridges native core memory requests onto a UART byte stream to a host memory server.
// Command byte, MSB-first address, LSB-first write data out; LSB-first read data or an ack byte back.
module mem_uart_bridge #(
    parameter int                   AddrWidth     = 32,
    parameter int                   DataWidth     = 32,
    parameter int                   TimeoutCycles = 1000000,
    parameter int                   PostedWrites  = 0,
    parameter logic [7:0]           AckByte       = 8'hA5,
    parameter logic [DataWidth-1:0] ErrData       = {DataWidth{1'b1}}
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_wstrb_i,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic                   err_o,
    output logic                   busy_o
);
    localparam int NB = DataWidth / 8;
    localparam int NA = AddrWidth / 8;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [3:0] A_LAST = 4'(NA - 1);
    localparam logic [3:0] D_LAST = 4'(NB - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RESP, DONE} state_t;

    state_t               state, state_n;
    logic [AddrWidth-1:0] addr_sh;
    logic [DataWidth-1:0] wd_sh;
    logic [DataWidth-1:0] rd_buf, rd_next;
    logic [NB-1:0]        wstrb_q;
    logic                 is_wr;
    logic [3:0]           idx;
    logic [TW-1:0]        tmo_cnt;
    logic                 err_q;
    logic [7:0]           cmd;
    logic                 tx_fire, rx_fire, tmo_hit, resp_last;

    assign tx_fire     = tx_valid_o & tx_ready_i;
    assign rx_fire     = rx_valid_i & rx_ready_o;
    assign tmo_hit     = (TimeoutCycles != 0) && (tmo_cnt == TMO_LAST);
    assign resp_last   = is_wr || (idx == D_LAST);
    assign mem_ready_o = (state == DONE);
    assign err_o       = (state == DONE) & err_q;
    assign busy_o      = (state != IDLE);

    always_comb begin
        cmd    = 8'(wstrb_q);
        cmd[7] = is_wr;
    end

    always_comb begin
        rd_next = rd_buf;
        rd_next[int'(idx)*8 +: 8] = rx_data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        rx_ready_o = 1'b0;
        case (state)
            IDLE: begin
                rx_ready_o = 1'b1;
                if (mem_valid_i) state_n = CMD;
            end
            CMD: begin
                tx_valid_o = 1'b1;
                tx_data_o  = cmd;
                if (tx_fire) state_n = ADDR;
            end
            ADDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = addr_sh[AddrWidth-1 -: 8];
                if (tx_fire && idx == A_LAST) state_n = is_wr ? WDATA : RESP;
            end
            WDATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = wd_sh[7:0];
                if (tx_fire && idx == D_LAST) state_n = (PostedWrites != 0) ? DONE : RESP;
            end
            RESP: begin
                rx_ready_o = 1'b1;
                // an arriving byte takes priority over an expiring timeout
                if (rx_fire) begin
                    if (resp_last) state_n = DONE;
                end else if (tmo_hit) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_sh     <= '0;
            wd_sh       <= '0;
            rd_buf      <= '0;
            wstrb_q     <= '0;
            is_wr       <= 1'b0;
            idx         <= '0;
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (mem_valid_i) begin
                    addr_sh <= mem_addr_i;
                    wd_sh   <= mem_wdata_i;
                    wstrb_q <= mem_wstrb_i;
                    is_wr   <= |mem_wstrb_i;
                    idx     <= '0;
                    tmo_cnt <= '0;
                    err_q   <= 1'b0;
                end
                ADDR: if (tx_fire) begin
                    addr_sh <= addr_sh << 8;
                    idx     <= (idx == A_LAST) ? 4'd0 : idx + 4'd1;
                end
                WDATA: if (tx_fire) begin
                    wd_sh <= wd_sh >> 8;
                    idx   <= (idx == D_LAST) ? 4'd0 : idx + 4'd1;
                end
                RESP: begin
                    if (rx_fire) begin
                        tmo_cnt <= '0;
                        idx     <= idx + 4'd1;
                        if (!is_wr) rd_buf <= rd_next;
                        if (resp_last) begin
                            // read data is published on entry to DONE so it is valid with mem_ready_o
                            if (is_wr) err_q       <= (rx_data_i != AckByte);
                            else       mem_rdata_o <= rd_next;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        if (!is_wr) mem_rdata_o <= ErrData;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
